pipeline_sequencer: RTL

Central stall/flush controller for the 5-stage MIPS pipeline. Watches the opcode in decode plus the load in execute, and drives PC write-enable, IF/ID enable and flush, and ID/EX bubble insertion. Sequences load-use stalls, two-cycle jump flushes, and halt/resume through a small FSM. Also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/load_use_detect.sv | 14 +
 rtl/pipeline_sequencer.sv | 99 +++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, FSM encoding and decode helpers for the pipeline stall/flush controller.
package pipe_ctrl_pkg;
  localparam logic [5:0] OP_HLT     = 6'b010001;
  localparam logic [5:0] OP_LD      = 6'b010100;
  localparam logic [3:0] JMP_PREFIX = 4'b0111;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    LDW  = 2'd1,
    JF   = 2'd2,
    HALT = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN   = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_bubble: 1'b0};
  localparam ctrl_t CTRL_STALL = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_bubble: 1'b1};

  function automatic logic is_jmp(input logic [5:0] op);
    return op[5:2] == JMP_PREFIX;
  endfunction
endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: the EX load writes a register that decode reads.
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             i_ex_ld,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  output logic             o_lu
);
  // Register 0 is hardwired, so a load into it never creates a dependency.
  assign o_lu = i_ex_ld && (i_ex_rd != '0) &&
                ((i_ex_rd == i_id_rs) || (i_ex_rd == i_id_rt));
endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, two-cycle jump
// flushes, halt/resume, and a saturating stall-cycle counter.
module pipeline_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_ld,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);
  seq_state_t       r_state;
  seq_state_t       w_next;
  ctrl_t            w_ctrl;
  logic             w_lu;
  logic             w_hlt;
  logic             w_jmp;
  logic [CNT_W-1:0] r_cnt;

  load_use_detect #(.REG_W(REG_W)) u_lu (
    .i_ex_ld (ex_ld),
    .i_ex_rd (ex_rd),
    .i_id_rs (id_rs),
    .i_id_rt (id_rt),
    .o_lu    (w_lu)
  );

  assign w_hlt = (op == OP_HLT);
  assign w_jmp = is_jmp(op);

  always_comb begin
    w_ctrl = CTRL_RUN;
    w_next = r_state;
    unique case (r_state)
      RUN, LDW: begin
        // LDW skips the LU check so the same load cannot stall twice.
        if (w_hlt) begin
          w_ctrl = CTRL_STALL;
          w_next = HALT;
        end else if (w_lu && r_state == RUN) begin
          w_ctrl = CTRL_STALL;
          w_next = LDW;
        end else if (w_jmp) begin
          w_ctrl.ifid_flush = 1'b1;
          w_next = JF;
        end else begin
          w_next = RUN;
        end
      end
      JF: begin
        w_ctrl.ifid_flush = 1'b1;
        w_next = RUN;
      end
      HALT: begin
        if (resume) begin
          w_ctrl.ifid_flush  = 1'b1;
          w_ctrl.idex_bubble = 1'b1;
          w_next = RUN;
        end else begin
          w_ctrl = CTRL_STALL;
        end
      end
      default: w_next = RUN;
    endcase
    if (!reset) begin
      w_ctrl = CTRL_STALL;
      w_next = RUN;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (!w_ctrl.pc_en && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign pc_en       = w_ctrl.pc_en;
  assign ifid_en     = w_ctrl.ifid_en;
  assign ifid_flush  = w_ctrl.ifid_flush;
  assign idex_bubble = w_ctrl.idex_bubble;
  assign halted      = (r_state == HALT);
  assign stall_cnt   = r_cnt;
endmodule
